decoder: RTL and testbench

- Slice-to-image assembler for the BNN input path.
- Collects an 8x8 binary image one 8-bit row slice at a time. Each slice is written into the row chosen by `sel`.
- Presents the full 64-bit image in parallel to the downstream BNN layer.
- Flags when a complete frame, all rows written, has been assembled.

---
 rtl/decoder.sv | 62 ++++++
 tb/tb_decoder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// Slice-to-image assembler: gathers NUM_SLICES rows of SLICE_W bits into one
// parallel binary image and flags when every row of the frame has been written.
module decoder #(
    parameter int unsigned SLICE_W    = 8,
    parameter int unsigned NUM_SLICES = 8,
    localparam int unsigned SEL_W     = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1,
    localparam int unsigned IMG_W     = SLICE_W * NUM_SLICES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SLICE_W-1:0] slice_i,
    input  logic [SEL_W-1:0]   sel,
    input  logic               en,
    output logic [IMG_W-1:0]   image_o,
    output logic [NUM_SLICES-1:0] row_mask_o,
    output logic               valid_o
);

    logic [IMG_W-1:0]      image_q, image_d;
    logic [NUM_SLICES-1:0] mask_q,  mask_d;
    logic                  valid_q, valid_d;
    logic                  sel_ok_c;

    // Row index is only honoured when it names an existing row.
    assign sel_ok_c = (32'(sel) < NUM_SLICES);

    // Next-state: write the selected row and track which rows this frame holds.
    always_comb begin
        image_d = image_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        if (en && sel_ok_c) begin
            image_d[32'(sel) * SLICE_W +: SLICE_W] = slice_i;
            if (valid_q) begin
                // A write after a completed frame opens a new one; old rows stay.
                mask_d      = '0;
                mask_d[sel] = 1'b1;
            end else begin
                mask_d[sel] = 1'b1;
            end
            valid_d = &mask_d;
        end
    end

    // State registers with synchronous reset taking priority over writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            image_q <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            image_q <= image_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
        end
    end

    assign image_o    = image_q;
    assign row_mask_o = mask_q;
    assign valid_o    = valid_q;

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: driver pushes hand-computed post-edge state,
// monitor pops and compares one entry after every clock edge.
module tb_decoder;

    typedef struct packed {
        logic [63:0] image;
        logic [7:0]  mask;
        logic        valid;
        logic [15:0] id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  slice_i;
    logic [2:0]  sel;
    logic        en;
    logic [63:0] image_o;
    logic [7:0]  row_mask_o;
    logic        valid_o;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_id = 0;
    bit   drive_done = 1'b0;

    decoder dut (
        .clk        (clk),
        .rst        (rst),
        .slice_i    (slice_i),
        .sel        (sel),
        .en         (en),
        .image_o    (image_o),
        .row_mask_o (row_mask_o),
        .valid_o    (valid_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input logic r, input logic e, input logic [2:0] s,
                        input logic [7:0] d, input logic [63:0] ei,
                        input logic [7:0] em, input logic ev);
        exp_t x;
        @(negedge clk);
        rst     = r;
        en      = e;
        sel     = s;
        slice_i = d;
        x.image = ei;
        x.mask  = em;
        x.valid = ev;
        x.id    = 16'(step_id);
        step_id++;
        exp_q.push_back(x);
    endtask

    // Monitor: compare DUT outputs against the oldest expected entry.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                n_tests++;
                if (image_o !== x.image) begin
                    n_fail++;
                    $display("FAIL image step %0d: got %h want %h", x.id, image_o, x.image);
                end
                n_tests++;
                if (row_mask_o !== x.mask) begin
                    n_fail++;
                    $display("FAIL mask step %0d: got %h want %h", x.id, row_mask_o, x.mask);
                end
                n_tests++;
                if (valid_o !== x.valid) begin
                    n_fail++;
                    $display("FAIL valid step %0d: got %b want %b", x.id, valid_o, x.valid);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; sel = 3'd0; slice_i = 8'h00;

        // Reset then idle
        step(1, 0, 0, 8'h00, 64'h0, 8'h00, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 3'(i), 8'hAA, 64'h0, 8'h00, 0);

        // Sequential fill: rows 0..6 = FF, row 7 = 00
        for (int i = 0; i < 7; i++)
            step(0, 1, 3'(i), 8'hFF, (64'h1 << (8 * (i + 1))) - 64'h1,
                 8'((9'h1 << (i + 1)) - 9'h1), 0);
        step(0, 1, 3'd7, 8'h00, 64'h00FF_FFFF_FFFF_FFFF, 8'hFF, 1);
        step(0, 0, 3'd2, 8'h12, 64'h00FF_FFFF_FFFF_FFFF, 8'hFF, 1);

        // New frame after valid: only row 0 changes
        step(0, 1, 3'd0, 8'h55, 64'h00FF_FFFF_FFFF_FF55, 8'h01, 0);

        // Out-of-order and overwrite from a clean frame
        step(1, 0, 0, 8'h00, 64'h0, 8'h00, 0);
        step(0, 1, 3'd5, 8'hA5, 64'h0000_A500_0000_0000, 8'h20, 0);
        step(0, 1, 3'd5, 8'h3C, 64'h0000_3C00_0000_0000, 8'h20, 0);
        step(0, 1, 3'd2, 8'h81, 64'h0000_3C00_0081_0000, 8'h24, 0);

        // Reset wins over a simultaneous write
        step(1, 1, 3'd3, 8'hFF, 64'h0, 8'h00, 0);
        step(0, 0, 3'd3, 8'hFF, 64'h0, 8'h00, 0);

        // Reverse-order fill
        step(0, 1, 3'd7, 8'h17, 64'h1700_0000_0000_0000, 8'h80, 0);
        step(0, 1, 3'd6, 8'h16, 64'h1716_0000_0000_0000, 8'hC0, 0);
        step(0, 1, 3'd5, 8'h15, 64'h1716_1500_0000_0000, 8'hE0, 0);
        step(0, 1, 3'd4, 8'h14, 64'h1716_1514_0000_0000, 8'hF0, 0);
        step(0, 1, 3'd3, 8'h13, 64'h1716_1514_1300_0000, 8'hF8, 0);
        step(0, 1, 3'd2, 8'h12, 64'h1716_1514_1312_0000, 8'hFC, 0);
        step(0, 1, 3'd1, 8'h11, 64'h1716_1514_1312_1100, 8'hFE, 0);
        step(0, 1, 3'd0, 8'h10, 64'h1716_1514_1312_1110, 8'hFF, 1);

        // en gating: inputs toggle, state holds
        step(0, 0, 3'd1, 8'hFF, 64'h1716_1514_1312_1110, 8'hFF, 1);
        step(0, 0, 3'd4, 8'h00, 64'h1716_1514_1312_1110, 8'hFF, 1);
        step(0, 0, 3'd6, 8'h5A, 64'h1716_1514_1312_1110, 8'hFF, 1);
        step(0, 0, 3'd7, 8'hA5, 64'h1716_1514_1312_1110, 8'hFF, 1);

        // New frame on row 6, then overwrite within that frame
        step(0, 1, 3'd6, 8'hEE, 64'h17EE_1514_1312_1110, 8'h40, 0);
        step(0, 1, 3'd6, 8'h77, 64'h1777_1514_1312_1110, 8'h40, 0);
        step(0, 1, 3'd1, 8'h99, 64'h1777_1514_1312_9910, 8'h42, 0);

        @(negedge clk);
        en = 1'b0;
        drive_done = 1'b1;
    end

    // Drain the scoreboard within a bounded number of cycles, then summarise.
    initial begin
        wait (drive_done);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
